// File: rtl/picosoc_bus_pkg.sv
// Shared definitions for the picosoc bus multiplexer: FSM encoding, error causes
// and the default read word returned on an error response.
package picosoc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10,
    ST_ERR  = 2'b11
  } bus_state_e;

  localparam logic [1:0]  ERR_NONE          = 2'b00;
  localparam logic [1:0]  ERR_UNMAPPED      = 2'b01;
  localparam logic [1:0]  ERR_TIMEOUT       = 2'b10;
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  function automatic int width_min1(input int w);
    return (w < 32'sd1) ? 32'sd1 : w;
  endfunction

endpackage

// File: rtl/picosoc_addr_decode.sv
// Combinational priority address decoder: hit flag plus the lowest matching
// slave index.
module picosoc_addr_decode #(
  parameter int                 NSLV     = 4,
  parameter int                 SEL_W    = 2,
  parameter logic [NSLV*32-1:0] SLV_BASE = '0,
  parameter logic [NSLV*32-1:0] SLV_MASK = '0
) (
  input  logic [31:0]      i_addr,
  output logic             o_hit,
  output logic [SEL_W-1:0] o_sel
);

  logic [NSLV-1:0] w_match;

  always_comb begin
    w_match = '0;
    for (int i = 0; i < NSLV; i++) begin
      w_match[i] = ((i_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]);
    end
  end

  assign o_hit = |w_match;

  // Scan downwards so the lowest matching index is the last one written.
  always_comb begin
    o_sel = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      o_sel = w_match[i] ? SEL_W'(i) : o_sel;
    end
  end

endmodule

// File: rtl/picosoc_busmux.sv
// Routes picosoc master requests to NSLV address-decoded slaves, with a
// per-request timeout and a sticky record of the last bus error.
module picosoc_busmux
  import picosoc_bus_pkg::*;
#(
  parameter int                 NSLV      = 4,
  parameter logic [NSLV*32-1:0] SLV_BASE  = '0,
  parameter logic [NSLV*32-1:0] SLV_MASK  = '0,
  parameter int                 TIMEOUT   = 1024,
  parameter logic [31:0]        ERR_RDATA = ERR_RDATA_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_valid,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  input  logic [3:0]         mem_wstrb,
  output logic               mem_ready,
  output logic [31:0]        mem_rdata,
  output logic [NSLV-1:0]    slv_valid,
  output logic [31:0]        slv_addr,
  output logic [31:0]        slv_wdata,
  output logic [3:0]         slv_wstrb,
  input  logic [NSLV-1:0]    slv_ready,
  input  logic [NSLV*32-1:0] slv_rdata,
  output logic               err_valid,
  output logic [1:0]         err_code,
  output logic [31:0]        err_addr,
  input  logic               err_clr,
  output logic               irq_buserr
);

  localparam int SEL_W = width_min1($clog2(NSLV));
  localparam int CNT_W = width_min1($clog2(TIMEOUT + 32'sd1));
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT > 32'sd0) ? (TIMEOUT - 32'sd1) : 32'sd0);

  bus_state_e       r_state, w_state_nxt;
  logic             w_hit;
  logic [SEL_W-1:0] w_dec_sel, w_sel_nxt, r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic             w_ready_sel, w_expire;
  logic             w_err_new;
  logic [1:0]       w_err_cause;
  logic [31:0]      w_err_addr;
  logic [31:0]      w_rdata_arr [NSLV];
  logic             w_mem_ready_nxt;
  logic [31:0]      w_mem_rdata_nxt;
  logic [NSLV-1:0]  w_slv_valid_nxt;

  logic             r_mem_ready;
  logic [31:0]      r_mem_rdata;
  logic [NSLV-1:0]  r_slv_valid;
  logic [31:0]      r_slv_addr, r_slv_wdata;
  logic [3:0]       r_slv_wstrb;
  logic             r_err_valid;
  logic [1:0]       r_err_code;
  logic [31:0]      r_err_addr;
  logic             r_irq;

  picosoc_addr_decode #(
    .NSLV     (NSLV),
    .SEL_W    (SEL_W),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decode (
    .i_addr (mem_addr),
    .o_hit  (w_hit),
    .o_sel  (w_dec_sel)
  );

  for (genvar g = 0; g < NSLV; g++) begin : g_rdata
    assign w_rdata_arr[g] = slv_rdata[32*g +: 32];
  end

  assign w_ready_sel = slv_ready[r_sel];
  // Expiry fires in the TIMEOUT-th REQ cycle; a ready in that same cycle still wins.
  assign w_expire    = (TIMEOUT > 32'sd0) && (r_cnt >= CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ERR lasts two cycles: error capture first, then the mem_ready beat.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (mem_valid) begin
          w_state_nxt = w_hit ? ST_REQ : ST_ERR;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (w_ready_sel) begin
          w_state_nxt = ST_RESP;
        end else if (w_expire) begin
          w_state_nxt = ST_ERR;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      ST_ERR:  w_state_nxt = r_mem_ready ? ST_IDLE : ST_ERR;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_sel_nxt       = (r_state == ST_IDLE) ? w_dec_sel : r_sel;
    w_slv_valid_nxt = '0;
    for (int i = 0; i < NSLV; i++) begin
      w_slv_valid_nxt[i] = (w_state_nxt == ST_REQ) && (w_sel_nxt == SEL_W'(i));
    end
    w_mem_ready_nxt = (w_state_nxt == ST_RESP) || ((r_state == ST_ERR) && !r_mem_ready);
    if (w_state_nxt == ST_RESP) begin
      w_mem_rdata_nxt = w_rdata_arr[r_sel];
    end else if (w_mem_ready_nxt) begin
      w_mem_rdata_nxt = ERR_RDATA;
    end else begin
      w_mem_rdata_nxt = '0;
    end
    w_err_new   = 1'b0;
    w_err_cause = ERR_NONE;
    w_err_addr  = '0;
    case (r_state)
      ST_IDLE: begin
        if (mem_valid && !w_hit) begin
          w_err_new   = 1'b1;
          w_err_cause = ERR_UNMAPPED;
          w_err_addr  = mem_addr;
        end else begin
          w_err_new   = 1'b0;
        end
      end
      ST_REQ: begin
        if (!w_ready_sel && w_expire) begin
          w_err_new   = 1'b1;
          w_err_cause = ERR_TIMEOUT;
          w_err_addr  = r_slv_addr;
        end else begin
          w_err_new   = 1'b0;
        end
      end
      default: w_err_new = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_ready <= 1'b0;
      r_mem_rdata <= '0;
      r_slv_valid <= '0;
      r_slv_addr  <= '0;
      r_slv_wdata <= '0;
      r_slv_wstrb <= '0;
      r_sel       <= '0;
      r_cnt       <= '0;
      r_err_valid <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_err_addr  <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_mem_ready <= w_mem_ready_nxt;
      r_mem_rdata <= w_mem_rdata_nxt;
      r_slv_valid <= w_slv_valid_nxt;
      r_irq       <= w_err_new;
      if ((r_state == ST_IDLE) && mem_valid) begin
        r_slv_addr  <= mem_addr;
        r_slv_wdata <= mem_wdata;
        r_slv_wstrb <= mem_wstrb;
        r_sel       <= w_dec_sel;
      end
      if (r_state == ST_REQ) begin
        if (r_cnt != '1) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
      // A fresh error takes priority over a simultaneous clear.
      if (w_err_new) begin
        r_err_valid <= 1'b1;
        r_err_code  <= w_err_cause;
        r_err_addr  <= w_err_addr;
      end else if (err_clr) begin
        r_err_valid <= 1'b0;
      end
    end
  end

  assign mem_ready  = r_mem_ready;
  assign mem_rdata  = r_mem_rdata;
  assign slv_valid  = r_slv_valid;
  assign slv_addr   = r_slv_addr;
  assign slv_wdata  = r_slv_wdata;
  assign slv_wstrb  = r_slv_wstrb;
  assign err_valid  = r_err_valid;
  assign err_code   = r_err_code;
  assign err_addr   = r_err_addr;
  assign irq_buserr = r_irq;

endmodule

// File: tb/tb_picosoc_busmux.sv
// Randomised plus directed bench for picosoc_busmux against a cycle-timeline
// reference model derived from the bus rules.
module tb_picosoc_busmux;
  import picosoc_bus_pkg::*;

  localparam int NSLV = 3;
  localparam int TMO  = 8;
  localparam logic [31:0] MASK = 32'hFF00_0000;
  localparam logic [NSLV*32-1:0] BASES = {32'h0200_0000, 32'h0100_0000, 32'h0000_0000};
  localparam logic [NSLV*32-1:0] MASKS = {MASK, MASK, MASK};
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic reset, mem_valid, mem_ready, err_clr, err_valid, irq_buserr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, slv_addr, slv_wdata, err_addr;
  logic [3:0]  mem_wstrb, slv_wstrb;
  logic [NSLV-1:0] slv_valid, slv_ready;
  logic [NSLV*32-1:0] slv_rdata;
  logic [1:0] err_code;

  int n_checks = 0;
  int n_fail   = 0;
  int txn_id   = 0;
  logic        m_ev;
  logic [1:0]  m_code;
  logic [31:0] m_addr;

  always #5 clk = ~clk;

  picosoc_busmux #(
    .NSLV (NSLV), .SLV_BASE (BASES), .SLV_MASK (MASKS), .TIMEOUT (TMO)
  ) dut (
    .clk (clk), .reset (reset),
    .mem_valid (mem_valid), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb), .mem_ready (mem_ready), .mem_rdata (mem_rdata),
    .slv_valid (slv_valid), .slv_addr (slv_addr), .slv_wdata (slv_wdata),
    .slv_wstrb (slv_wstrb), .slv_ready (slv_ready), .slv_rdata (slv_rdata),
    .err_valid (err_valid), .err_code (err_code), .err_addr (err_addr),
    .err_clr (err_clr), .irq_buserr (irq_buserr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s txn=%0d got=%h exp=%h", tag, txn_id, got, exp);
    end
  endtask

  function automatic int model_sel(input logic [31:0] a);
    for (int i = 0; i < NSLV; i++) begin
      if ((a & MASKS[32*i +: 32]) == BASES[32*i +: 32]) return i;
    end
    return -1;
  endfunction

  task automatic check_all_zero(input string p);
    check_eq({p, "mem_ready"}, 32'(mem_ready), 32'd0);
    check_eq({p, "mem_rdata"}, mem_rdata, 32'd0);
    check_eq({p, "slv_valid"}, 32'(slv_valid), 32'd0);
    check_eq({p, "slv_addr"},  slv_addr, 32'd0);
    check_eq({p, "slv_wdata"}, slv_wdata, 32'd0);
    check_eq({p, "slv_wstrb"}, 32'(slv_wstrb), 32'd0);
    check_eq({p, "err_valid"}, 32'(err_valid), 32'd0);
    check_eq({p, "err_code"},  32'(err_code), 32'd0);
    check_eq({p, "err_addr"},  err_addr, 32'd0);
    check_eq({p, "irq"},       32'(irq_buserr), 32'd0);
  endtask

  // One master transaction; lat = REQ cycles the selected slave waits before ready.
  // clr_mode: 0 never clear, 1 random clears, 2 clear exactly on the error edge.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int lat,
                         input logic [31:0] rdata, input int clr_mode);
    int sel, r, n_resp, err_edge, vld_last;
    logic [1:0]  cause;
    logic [31:0] exp_rd;
    logic [2:0]  exp_vld, noise;
    logic        clr;
    sel = model_sel(addr);
    r   = lat + 1;
    if (sel < 0) begin
      n_resp = 2; err_edge = 0; vld_last = 0; cause = ERR_UNMAPPED; exp_rd = ERR_WORD;
    end else if (r <= TMO) begin
      n_resp = r + 1; err_edge = -1; vld_last = r; cause = ERR_NONE; exp_rd = rdata;
    end else begin
      n_resp = TMO + 2; err_edge = TMO; vld_last = TMO; cause = ERR_TIMEOUT; exp_rd = ERR_WORD;
    end
    txn_id++;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    for (int c = 0; c <= n_resp + 1; c++) begin
      if (c > 0) begin
        exp_vld = (c <= vld_last) ? (3'b001 << sel) : 3'b000;
        check_eq("slv_valid", 32'(slv_valid), 32'(exp_vld));
        check_eq("mem_ready", 32'(mem_ready), 32'(c == n_resp));
        check_eq("mem_rdata", mem_rdata, (c == n_resp) ? exp_rd : 32'd0);
        check_eq("irq", 32'(irq_buserr), 32'((err_edge >= 0) && (c == err_edge + 1)));
        check_eq("err_valid", 32'(err_valid), 32'(m_ev));
        check_eq("err_code", 32'(err_code), 32'(m_code));
        check_eq("err_addr", err_addr, m_addr);
        if (c <= vld_last) begin
          check_eq("slv_addr", slv_addr, addr);
          check_eq("slv_wdata", slv_wdata, wdata);
          check_eq("slv_wstrb", 32'(slv_wstrb), 32'(wstrb));
        end
      end
      mem_valid = (c <= n_resp);
      noise = 3'($urandom);
      slv_rdata = {$urandom, $urandom, $urandom};
      if (sel >= 0) begin
        noise[sel] = (c == r);
        slv_rdata[32*sel +: 32] = rdata;
      end
      slv_ready = noise;
      if (clr_mode == 1) clr = ($urandom_range(0, 3) == 0);
      else clr = (clr_mode == 2) && (c == err_edge);
      err_clr = clr;
      @(posedge clk);
      if (c == err_edge) begin
        m_ev = 1'b1; m_code = cause; m_addr = addr;
      end else if (clr) begin
        m_ev = 1'b0;
      end
      #1;
    end
    err_clr   = 1'b0;
    mem_valid = 1'b0;
    slv_ready = '0;
  endtask

  task automatic reset_in_req();
    txn_id++;
    mem_addr = 32'h0100_0020; mem_wdata = 32'h0F0F_0F0F; mem_wstrb = 4'hF;
    mem_valid = 1'b1; slv_ready = '0; err_clr = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_pre_vld", 32'(slv_valid), 32'(3'b010));
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check_all_zero("rst_mid_");
    m_ev = 1'b0; m_code = ERR_NONE; m_addr = 32'd0;
    mem_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog txn=%0d", txn_id);
    $fatal(1, "bench timed out");
  end

  initial begin
    reset = 1'b1; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    slv_ready = '0; slv_rdata = '0; err_clr = 1'b0;
    m_ev = 1'b0; m_code = ERR_NONE; m_addr = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("por_");
    reset = 1'b0;
    run_txn(32'h0100_0010, 32'h0000_0000, 4'b0000, 0,       32'h1234_5678, 0);
    run_txn(32'h0000_0004, 32'hA5A5_A5A5, 4'b0011, 3,       32'h7777_0000, 0);
    run_txn(32'h0300_0000, 32'h0000_0000, 4'b0000, 0,       32'h0000_0000, 0);
    run_txn(32'h0200_0040, 32'h0000_0000, 4'b0000, 100,     32'h5555_0000, 0);
    run_txn(32'h0200_0044, 32'h0000_0000, 4'b0000, TMO - 1, 32'h0BAD_F00D, 0);
    run_txn(32'h0400_1234, 32'h0000_0000, 4'b0000, 0,       32'h0000_0000, 2);
    reset_in_req();
    run_txn(32'h0100_0080, 32'h1357_9BDF, 4'b1111, 1,       32'hCAFE_0001, 0);
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      int lat;
      a   = {8'($urandom_range(0, 4)), 24'($urandom)};
      lat = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 11) : $urandom_range(0, 4);
      run_txn(a, $urandom, 4'($urandom), lat, $urandom, 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
